// File: rtl/trigger_link_framer.sv
// rtl/trigger_link_framer.sv - per-link BX frame builder for the 80 MHz MGT TX user interface
// Each BX goes out as {payload[23:0], K marker} then payload[55:24]; non-RUN links send K28.5 idle.
module trigger_link_framer #(
  parameter int NLINKS            = 4,
  parameter int NCLUSTERS         = 8,
  parameter int CLUSTERS_PER_LINK = 4,
  parameter int CLUSTER_BITS      = 14,
  parameter int IDLE_BX           = 16
) (
  input  logic                              clk_80,
  input  logic                              reset_n,
  input  logic                              ce_40,
  input  logic [NCLUSTERS*CLUSTER_BITS-1:0] clusters,
  input  logic                              ttc_bx0,
  input  logic                              overflow,
  input  logic [NLINKS-1:0]                 tx_ready,
  input  logic [NLINKS-1:0]                 link_enable,
  input  logic                              test_mode,
  output logic [NLINKS*32-1:0]              tx_data,
  output logic [NLINKS*4-1:0]               tx_charisk,
  output logic [NLINKS-1:0]                 link_running,
  output logic [NCLUSTERS-1:0]              valid_clusters,
  output logic                              valid_clusters_or,
  output logic                              phase_err
);

  localparam int          PAYLOAD_BITS = CLUSTERS_PER_LINK * CLUSTER_BITS;
  localparam int          NGROUPS      = NCLUSTERS / CLUSTERS_PER_LINK;
  localparam logic [31:0] IDLE_WORD    = 32'h000000BC;
  localparam logic [7:0]  IDLE_BX_C    = 8'(IDLE_BX);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;

  logic [7:0]           marker;
  logic                 phase_q, phase_d;
  logic                 phase_err_q, phase_err_d;
  logic                 phase_bad;
  logic [NCLUSTERS-1:0] valid_q, valid_d;

  always_comb begin
    marker = 8'hBC;
    if (ttc_bx0)       marker = 8'h3C;
    else if (overflow) marker = 8'h5C;
  end

  // ce_40 belongs on phase 0; whichever slot it actually lands in re-anchors the phase
  always_comb begin
    phase_bad   = ce_40 ? phase_q : ~phase_q;
    phase_d     = ce_40 ? 1'b1 : ~phase_q;
    phase_err_d = phase_err_q | phase_bad;
  end

  always_comb begin
    valid_d = valid_q;
    if (ce_40) begin
      for (int i = 0; i < NCLUSTERS; i++) begin
        valid_d[i] = (clusters[i*CLUSTER_BITS+9 +: 2] != 2'b11);
      end
    end
  end

  always_ff @(posedge clk_80 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= 1'b0;
      phase_err_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      phase_err_q <= phase_err_d;
      valid_q     <= valid_d;
    end
  end

  assign valid_clusters    = valid_q;
  assign valid_clusters_or = |valid_q;
  assign phase_err         = phase_err_q;

  for (genvar k = 0; k < NLINKS; k++) begin : g_link
    localparam int GROUP = k % NGROUPS;

    state_t                  state_q, state_d;
    logic [7:0]              good_q, good_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              good_inc;
    logic [7:0]              tcnt;
    logic [31:0]             data_q, data_d;
    logic [3:0]              isk_q, isk_d;
    logic [31:0]             hi_q, hi_d;
    logic                    hi_vld_q, hi_vld_d;
    logic                    run_q, run_d;
    logic                    link_ok;
    logic [PAYLOAD_BITS-1:0] payload;

    always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      link_ok  = tx_ready[k] & link_enable[k];
      good_inc = good_q + 8'd1;
      if (phase_bad && (state_q != ST_RUN)) begin
        state_d = ST_IDLE;
        good_d  = 8'd0;
      end else if (ce_40) begin
        case (state_q)
          ST_IDLE: begin
            if (link_ok) begin
              state_d = ST_SYNC;
              good_d  = 8'd0;
            end
          end
          ST_SYNC: begin
            if (!link_ok) begin
              state_d = ST_IDLE;
              good_d  = 8'd0;
            end else if (good_inc == IDLE_BX_C) begin
              state_d = ST_RUN;
              good_d  = 8'd0;
            end else begin
              good_d = good_inc;
            end
          end
          ST_RUN: begin
            if (!link_ok) state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
            good_d  = 8'd0;
          end
        endcase
      end
    end

    // A fresh entry to RUN sends count 0 regardless of what the counter held before
    always_comb begin
      cnt_d    = cnt_q;
      data_d   = IDLE_WORD;
      isk_d    = 4'b0001;
      hi_d     = hi_q;
      hi_vld_d = 1'b0;
      run_d    = (state_d == ST_RUN);
      tcnt     = (state_q == ST_RUN) ? cnt_q : 8'd0;
      payload  = test_mode ? {(PAYLOAD_BITS/8){tcnt}}
                           : clusters[GROUP*PAYLOAD_BITS +: PAYLOAD_BITS];
      if (ce_40) begin
        if (state_d == ST_RUN) begin
          data_d   = {payload[23:0], marker};
          isk_d    = 4'b0001;
          hi_d     = payload[PAYLOAD_BITS-1:24];
          hi_vld_d = 1'b1;
          cnt_d    = tcnt + 8'd1;
        end
      end else if (hi_vld_q) begin
        data_d = hi_q;
        isk_d  = 4'b0000;
      end
    end

    always_ff @(posedge clk_80 or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_IDLE;
        good_q   <= 8'd0;
        cnt_q    <= 8'd0;
        data_q   <= IDLE_WORD;
        isk_q    <= 4'b0001;
        hi_q     <= 32'd0;
        hi_vld_q <= 1'b0;
        run_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        good_q   <= good_d;
        cnt_q    <= cnt_d;
        data_q   <= data_d;
        isk_q    <= isk_d;
        hi_q     <= hi_d;
        hi_vld_q <= hi_vld_d;
        run_q    <= run_d;
      end
    end

    assign tx_data[k*32 +: 32]  = data_q;
    assign tx_charisk[k*4 +: 4] = isk_q;
    assign link_running[k]      = run_q;
  end

endmodule

// File: tb/tb_trigger_link_framer.sv
// tb/tb_trigger_link_framer.sv - self-checking bench for trigger_link_framer
// Per-cycle comparison against a frame-queue reference model, plus vector table and directed sequences.
module tb_trigger_link_framer;

  localparam int NL = 4;
  localparam int NC = 8;
  localparam int CPL = 4;
  localparam int CB = 14;
  localparam int IDLE_BX = 16;

  logic              clk_80;
  logic              reset_n;
  logic              ce_40;
  logic [NC*CB-1:0]  clusters;
  logic              ttc_bx0;
  logic              overflow;
  logic [NL-1:0]     tx_ready;
  logic [NL-1:0]     link_enable;
  logic              test_mode;
  logic [NL*32-1:0]  tx_data;
  logic [NL*4-1:0]   tx_charisk;
  logic [NL-1:0]     link_running;
  logic [NC-1:0]     valid_clusters;
  logic              valid_clusters_or;
  logic              phase_err;

  logic [13:0] cl [NC];
  int n_checks = 0;
  int n_errors = 0;

  trigger_link_framer #(
    .NLINKS(NL), .NCLUSTERS(NC), .CLUSTERS_PER_LINK(CPL), .CLUSTER_BITS(CB), .IDLE_BX(IDLE_BX)
  ) dut (
    .clk_80(clk_80), .reset_n(reset_n), .ce_40(ce_40), .clusters(clusters),
    .ttc_bx0(ttc_bx0), .overflow(overflow), .tx_ready(tx_ready), .link_enable(link_enable),
    .test_mode(test_mode), .tx_data(tx_data), .tx_charisk(tx_charisk),
    .link_running(link_running), .valid_clusters(valid_clusters),
    .valid_clusters_or(valid_clusters_or), .phase_err(phase_err)
  );

  initial clk_80 = 1'b0;
  always #5 clk_80 = ~clk_80;

  // Reference model: link state as an integer (-1 idle, 0..IDLE_BX-1 sync, IDLE_BX run)
  int               mst  [NL];
  int               mcnt [NL];
  logic [35:0]      wq   [NL][$];
  bit               mphase;
  bit               merr;
  logic [NC-1:0]    mvalid;
  logic [NL*32-1:0] e_data;
  logic [NL*4-1:0]  e_isk;
  logic [NL-1:0]    e_run;

  typedef struct {
    logic        bx0;
    logic        ovf;
    logic [13:0] c0;
    logic [13:0] c3;
    logic [13:0] oth;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  vld;
    logic        vor;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      mst[k]  = -1;
      mcnt[k] = 0;
      wq[k].delete();
    end
    mphase = 1'b0;
    merr   = 1'b0;
    mvalid = '0;
    e_data = {NL{32'h000000BC}};
    e_isk  = {NL{4'b0001}};
    e_run  = '0;
  endtask

  task automatic model_step();
    bit          bad;
    bit          ok;
    logic [55:0] p;
    logic [7:0]  mk;
    logic [35:0] w;
    bad    = ce_40 ? mphase : !mphase;
    merr   = merr | bad;
    mphase = ce_40 ? 1'b1 : !mphase;
    mk     = ttc_bx0 ? 8'h3C : (overflow ? 8'h5C : 8'hBC);
    if (ce_40) begin
      for (int i = 0; i < NC; i++) mvalid[i] = (cl[i][10:9] != 2'b11);
    end
    for (int k = 0; k < NL; k++) begin
      ok = tx_ready[k] && link_enable[k];
      if (bad && mst[k] != IDLE_BX) mst[k] = -1;
      else if (ce_40) begin
        if (!ok) mst[k] = -1;
        else if (mst[k] < IDLE_BX) begin
          mst[k]++;
          if (mst[k] == IDLE_BX) mcnt[k] = 0;
        end
      end
      if (ce_40) begin
        wq[k].delete();
        if (mst[k] == IDLE_BX) begin
          p = '0;
          if (test_mode) begin
            for (int b = 0; b < 7; b++) p[b*8 +: 8] = 8'(mcnt[k]);
          end else begin
            for (int j = 0; j < CPL; j++) p[j*CB +: CB] = cl[(k % (NC/CPL))*CPL + j];
          end
          mcnt[k] = (mcnt[k] + 1) % 256;
          wq[k].push_back({4'b0001, p[23:0], mk});
          wq[k].push_back({4'b0000, p[55:24]});
        end
      end
      if (wq[k].size() > 0) w = wq[k].pop_front();
      else w = {4'b0001, 32'h000000BC};
      e_data[k*32 +: 32] = w[31:0];
      e_isk[k*4 +: 4]    = w[35:32];
      e_run[k]           = (mst[k] == IDLE_BX);
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < NC; i++) clusters[i*CB +: CB] = cl[i];
    model_step();
    @(posedge clk_80);
    #1;
    chk("tx_data", tx_data, e_data);
    chk("tx_charisk", tx_charisk, e_isk);
    chk("link_running", link_running, e_run);
    chk("valid_clusters", valid_clusters, mvalid);
    chk("valid_or", valid_clusters_or, |mvalid);
    chk("phase_err", phase_err, merr);
  endtask

  task automatic bx();
    ce_40 = 1'b1;
    cycle();
    ce_40 = 1'b0;
    cycle();
  endtask

  task automatic tm_bx(input string nm, input logic [31:0] w0, input logic [31:0] w1);
    ce_40 = 1'b1;
    cycle();
    chk(nm, tx_data[31:0], w0);
    ce_40 = 1'b0;
    cycle();
    chk(nm, tx_data[31:0], w1);
  endtask

  initial begin
    int len;
    vt[0] = '{1'b1, 1'b1, 14'h0123, 14'h0000, 14'h0000, 32'h0001233C, 32'h00000000, 8'hFF, 1'b1};
    vt[1] = '{1'b0, 1'b1, 14'h0600, 14'h0000, 14'h0000, 32'h0006005C, 32'h00000000, 8'hFE, 1'b1};
    vt[2] = '{1'b0, 1'b0, 14'h3FFF, 14'h2AAA, 14'h0000, 32'h003FFFBC, 32'hAAA80000, 8'hFE, 1'b1};
    vt[3] = '{1'b1, 1'b0, 14'h0000, 14'h0600, 14'h0000, 32'h0000003C, 32'h18000000, 8'hF7, 1'b1};
    vt[4] = '{1'b0, 1'b0, 14'h0600, 14'h0600, 14'h0600, 32'h800600BC, 32'h18006001, 8'h00, 1'b0};

    reset_n = 1'b0; ce_40 = 1'b0; ttc_bx0 = 1'b0; overflow = 1'b0; test_mode = 1'b0;
    tx_ready = '1; link_enable = '1;
    for (int i = 0; i < NC; i++) cl[i] = 14'h0000;
    cl[0] = 14'h0123;
    for (int i = 0; i < NC; i++) clusters[i*CB +: CB] = cl[i];
    model_reset();
    repeat (3) @(posedge clk_80);
    #1;
    chk("rst_tx_data", tx_data, {NL{32'h000000BC}});
    chk("rst_charisk", tx_charisk, {NL{4'b0001}});
    chk("rst_running", link_running, 4'b0000);
    chk("rst_valid", valid_clusters, 8'h00);
    chk("rst_phase_err", phase_err, 1'b0);
    reset_n = 1'b1;

    // startup: 16 good BXs in sync, RUN on BX 17
    repeat (16) bx();
    chk("run_after_16", link_running, 4'b0000);
    ce_40 = 1'b1;
    cycle();
    chk("run_on_17", link_running, 4'hF);
    chk("cl0_in_word0", tx_data[21:8], 14'h0123);
    ce_40 = 1'b0;
    cycle();

    // marker / payload / validity vectors; link2 mirrors link0
    for (int v = 0; v < 5; v++) begin
      ttc_bx0  = vt[v].bx0;
      overflow = vt[v].ovf;
      for (int i = 0; i < NC; i++) cl[i] = vt[v].oth;
      cl[0] = vt[v].c0;
      cl[3] = vt[v].c3;
      ce_40 = 1'b1;
      cycle();
      chk("vec_w0_link0", tx_data[31:0], vt[v].w0);
      chk("vec_w0_link2", tx_data[95:64], vt[v].w0);
      chk("vec_valid", valid_clusters, vt[v].vld);
      chk("vec_valid_or", valid_clusters_or, vt[v].vor);
      ce_40 = 1'b0;
      cycle();
      chk("vec_w1_link0", tx_data[31:0], vt[v].w1);
    end

    // counter test pattern from a fresh RUN entry, through the 8-bit wrap
    ttc_bx0 = 1'b0; overflow = 1'b0; test_mode = 1'b1;
    link_enable = '0;
    bx();
    link_enable = '1;
    repeat (16) bx();
    tm_bx("tm_first", 32'h000000BC, 32'h00000000);
    tm_bx("tm_second", 32'h010101BC, 32'h01010101);
    repeat (253) bx();
    tm_bx("tm_ff", 32'hFFFFFFBC, 32'hFFFFFFFF);
    tm_bx("tm_wrap", 32'h000000BC, 32'h00000000);

    // tx_ready[1] drop mid-RUN and recovery with counter restart
    tx_ready = 4'b1101;
    ce_40 = 1'b1;
    cycle();
    chk("drop_running", link_running, 4'b1101);
    chk("drop_link1_idle", tx_data[63:32], 32'h000000BC);
    ce_40 = 1'b0;
    cycle();
    tx_ready = '1;
    repeat (16) bx();
    chk("link1_not_yet", link_running, 4'b1101);
    ce_40 = 1'b1;
    cycle();
    chk("link1_back", link_running, 4'hF);
    ce_40 = 1'b0;
    cycle();
    chk("link1_cnt_restart", tx_data[63:32], 32'h00000000);

    // early ce_40 with link3 in SYNC
    test_mode = 1'b0;
    link_enable = 4'b0111;
    bx();
    link_enable = '1;
    repeat (3) bx();
    ce_40 = 1'b1;
    cycle();
    cycle();
    chk("perr_set", phase_err, 1'b1);
    chk("perr_run_kept", link_running, 4'b0111);
    ce_40 = 1'b0;
    cycle();
    repeat (16) bx();
    chk("perr_sticky", phase_err, 1'b1);
    chk("link3_pending", link_running, 4'b0111);
    bx();
    chk("link3_resync", link_running, 4'hF);

    // randomized traffic with occasional BX-length jitter
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NC; i++) cl[i] = 14'($urandom);
      ttc_bx0  = ($urandom_range(0, 7) == 0);
      overflow = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) test_mode = ~test_mode;
      for (int k = 0; k < NL; k++) begin
        tx_ready[k]    = ($urandom_range(0, 39) != 0);
        link_enable[k] = ($urandom_range(0, 39) != 0);
      end
      len = $urandom_range(0, 29);
      ce_40 = 1'b1;
      cycle();
      ce_40 = 1'b0;
      if (len != 0) cycle();
      if (len == 1) cycle();
    end

    // only reset clears the sticky phase error
    @(negedge clk_80);
    reset_n = 1'b0;
    #1;
    chk("rst2_phase_err", phase_err, 1'b0);
    chk("rst2_tx_data", tx_data, {NL{32'h000000BC}});
    chk("rst2_running", link_running, 4'b0000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_link_framer.md
Name: trigger_link_framer

Overview:
Parametrised successor to the fixed 4-link/8-cluster trigger link front end. It is the per-link frame builder that feeds the 80 MHz GTX/GTP TX user interface (usrclk2 domain). The block:
- maps NCLUSTERS S-bit clusters onto NLINKS links in groups of CLUSTERS_PER_LINK, wrapping so that extra links mirror earlier groups;
- frames each BX as two 32-bit words with a K-character marker that encodes BC0 and overflow;
- runs a per-link startup/idle state machine, a per-link enable mask, a counter test-pattern mode and BX-phase checking.

Parameters:
NLINKS, 4, number of TX links (1..8)
NCLUSTERS, 8, number of input clusters; must be a multiple of CLUSTERS_PER_LINK
CLUSTERS_PER_LINK, 4, clusters carried per link per BX; CLUSTERS_PER_LINK*CLUSTER_BITS must equal 56
CLUSTER_BITS, 14, width of one cluster word
IDLE_BX, 16, consecutive good BXs with tx_ready required before leaving IDLE (1..255)

Ports:
clk_80  input  1  80 MHz TX usrclk2; the only clock
reset_n  input  1  asynchronous, active-low reset
ce_40  input  1  one-cycle strobe marking the first clk_80 cycle of each BX
clusters  input  NCLUSTERS*CLUSTER_BITS  cluster i at bits [i*14+13:i*14]
ttc_bx0  input  1  BC0 for the BX being captured (sampled on ce_40)
overflow  input  1  cluster overflow for the BX being captured (sampled on ce_40)
tx_ready  input  NLINKS  per-link MGT reset-done and PLL-locked, already synchronised
link_enable  input  NLINKS  per-link enable; 0 forces idle
test_mode  input  1  1 = send counter pattern instead of clusters
tx_data  output  NLINKS*32  link k at [k*32+31:k*32]
tx_charisk  output  NLINKS*4  link k at [k*4+3:k*4]
link_running  output  NLINKS  link k is in RUN
valid_clusters  output  NCLUSTERS  registered per-cluster valid
valid_clusters_or  output  1  OR of valid_clusters (combinational from the register)
phase_err  output  1  sticky BX-phase error

Behaviour:
- Reset (reset_n=0, async), all outputs:
  - every tx_data word = 32'h000000BC (idle); every tx_charisk nibble = 4'b0001;
  - link_running=0, valid_clusters=0, phase_err=0;
  - all links enter IDLE with good-BX count 0; phase counter 0; test counters 0.
- Cluster validity: valid_clusters[i] <= ~(cluster_i[10:9]==2'b11). Updated on ce_40 cycles only.
- Capture on the ce_40 cycle (t):
  - payload for group g = {cluster(g*C+C-1), ..., cluster(g*C)}, 56 bits;
  - link k uses group g = k mod (NCLUSTERS/C);
  - bx0 and overflow latched with the payload.
- Marker byte:
  - ttc_bx0=1 -> 8'h3C (K28.1), regardless of overflow;
  - else overflow=1 -> 8'h5C (K28.2);
  - else 8'hBC (K28.5).
- RUN output for link k, 1-cycle latency:
  - t+1: tx_data = {payload[23:0], marker}, charisk 4'b0001;
  - t+2: tx_data = payload[55:24], charisk 4'b0000.
- test_mode=1 in RUN:
  - payload replaced by {7{cnt_k}}, with cnt_k an 8-bit per-link counter;
  - cnt_k increments once per BX sent in RUN and wraps 255 -> 0;
  - cnt_k clears to 0 on entry to RUN;
  - marker rules are unchanged.
- Idle word: 32'h000000BC with charisk 4'b0001. Sent on both cycles of each BX in any state other than RUN.
- Per-link state machine, evaluated on ce_40 cycles:
  - IDLE -> SYNC when tx_ready[k] & link_enable[k];
  - SYNC: counts good BXs; any BX with tx_ready[k]=0, link_enable[k]=0 or phase error -> back to IDLE with count 0; count reaching IDLE_BX -> RUN;
  - RUN -> IDLE on tx_ready[k]=0 or link_enable[k]=0. The idle word replaces the frame starting at the next t+1; a frame already half-sent completes its second word.
- link_running[k] = 1 in RUN. It is registered and changes on the same cycle as the first RUN word.
- Phase check:
  - a 1-bit phase toggles every cycle; ce_40 is expected when phase=0;
  - ce_40 arriving with phase=1, or phase=0 without ce_40, sets phase_err (sticky until reset) and drops every SYNC link to IDLE;
  - RUN links are unaffected by a phase error;
  - the phase realigns to the ce_40 that arrived.
- A ce_40 arriving in the t+1 slot: the second word of the frame is abandoned and a new frame starts at the next cycle.

Test Plan:
1. Reset release, tx_ready=all 1, enable=all 1, ce_40 every 2nd cycle -> idle words 32'h000000BC until 16 BXs; link_running goes 1 on BX 17; cluster0=14'h0123 shows in link0 word0 bits [21:8].
2. NLINKS=4, NCLUSTERS=8 -> link2 data equals link0 and link3 equals link1 on every cycle.
3. ttc_bx0 and overflow both 1 -> marker 8'h3C; overflow only -> 8'h5C; next BX with neither -> 8'hBC.
4. test_mode=1 in RUN -> link0 word0 = 32'h000000BC then 32'h00000000, next BX 32'h010101BC / 32'h01010101; cnt wraps 8'hFF -> 8'h00.
5. tx_ready[1] drops mid-RUN -> link1 idle from the next BX, other links unaffected; on return, link1 re-runs after 16 BXs with cnt restarted at 0.
6. ce_40 arrives one cycle early -> phase_err=1 and stays 1, SYNC links reset, RUN links continue; only reset_n clears phase_err.
